// File: rtl/alu_pkg.sv
// Shared constants for the CFT ALU front end: word width, microcode
// IBus addresses and the action field codes.
package alu_pkg;

    localparam int unsigned WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    localparam logic [4:0] RADDR_ALU_B = 5'h07;
    localparam logic [4:0] WADDR_ALU_B = 5'h07;
    localparam logic [1:0] RADDR_ROM   = 2'b11;

    typedef enum logic [3:0] {
        ACT_CLL = 4'b1001,
        ACT_CPL = 4'b1010,
        ACT_SRU = 4'b1011,
        ACT_101 = 4'b1101,
        ACT_110 = 4'b1110
    } action_e;

endpackage

// File: rtl/alu_input_stage_if.sv
// Microcode inputs, operand outputs and active-low strobes of the ALU
// input stage; the bidirectional IBus stays a plain inout on the top.
interface alu_input_stage_if;
    import alu_pkg::*;

    logic       t34;
    logic [4:0] raddr;
    logic [4:0] waddr;
    logic [3:0] action;
    word_t      ac;
    logic       nbcp_sru;

    word_t      a;
    word_t      b;
    logic       nromoe;
    logic       nread_alu_b;
    logic       nwrite_alu_b;
    logic       naction_cll;
    logic       naction_cpl;
    logic       naction_sru;
    logic       naction_101;
    logic       naction_110;

    modport slave (
        input  t34, raddr, waddr, action, ac, nbcp_sru,
        output a, b, nromoe, nread_alu_b, nwrite_alu_b,
               naction_cll, naction_cpl, naction_sru, naction_101, naction_110
    );

    modport master (
        output t34, raddr, waddr, action, ac, nbcp_sru,
        input  a, b, nromoe, nread_alu_b, nwrite_alu_b,
               naction_cll, naction_cpl, naction_sru, naction_101, naction_110
    );

endinterface

// File: rtl/alu_strobe_decode.sv
// Combinational microcode decoder: ROM enable, B read/write strobes and
// the five active-low action strobes.
module alu_strobe_decode
    import alu_pkg::*;
(
    input  logic       i_t34,
    input  logic [4:0] i_raddr,
    input  logic [4:0] i_waddr,
    input  logic [3:0] i_action,
    output logic       o_nromoe,
    output logic       o_nread_alu_b,
    output logic       o_nwrite_alu_b,
    output logic       o_naction_cll,
    output logic       o_naction_cpl,
    output logic       o_naction_sru,
    output logic       o_naction_101,
    output logic       o_naction_110
);

    // Reads are not phase-qualified; writes and actions only fire in T3-T4.
    always_comb begin
        o_nromoe       = (i_raddr[4:3] == RADDR_ROM)   ? 1'b0 : 1'b1;
        o_nread_alu_b  = (i_raddr == RADDR_ALU_B)      ? 1'b0 : 1'b1;
        o_nwrite_alu_b = (i_t34 && (i_waddr == WADDR_ALU_B)) ? 1'b0 : 1'b1;

        o_naction_cll = 1'b1;
        o_naction_cpl = 1'b1;
        o_naction_sru = 1'b1;
        o_naction_101 = 1'b1;
        o_naction_110 = 1'b1;
        if (i_t34) begin
            case (i_action)
                ACT_CLL: o_naction_cll = 1'b0;
                ACT_CPL: o_naction_cpl = 1'b0;
                ACT_SRU: o_naction_sru = 1'b0;
                ACT_101: o_naction_101 = 1'b0;
                ACT_110: o_naction_110 = 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_input_stage.sv
// ALU front end: strobe decoder, operand registers A/B and the IBus
// read-back driver for B.
module alu_input_stage
    import alu_pkg::*;
(
    input  logic              clk4,
    input  logic              nreset,
    alu_input_stage_if.slave  bus,
    inout  wire  [WORD_W-1:0] ibus
);

    logic  w_nread_alu_b;
    logic  w_nwrite_alu_b;
    logic  w_load_b;
    word_t r_a;
    word_t r_b;

    alu_strobe_decode u_decode (
        .i_t34          (bus.t34),
        .i_raddr        (bus.raddr),
        .i_waddr        (bus.waddr),
        .i_action       (bus.action),
        .o_nromoe       (bus.nromoe),
        .o_nread_alu_b  (w_nread_alu_b),
        .o_nwrite_alu_b (w_nwrite_alu_b),
        .o_naction_cll  (bus.naction_cll),
        .o_naction_cpl  (bus.naction_cpl),
        .o_naction_sru  (bus.naction_sru),
        .o_naction_101  (bus.naction_101),
        .o_naction_110  (bus.naction_110)
    );

    // Microcode write and SRU request share one load path from the IBus.
    assign w_load_b = ~w_nwrite_alu_b | ~bus.nbcp_sru;

    always_ff @(posedge clk4 or negedge nreset) begin
        if (!nreset) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            r_a <= bus.ac;
            if (w_load_b) begin
                r_b <= ibus;
            end
        end
    end

    assign ibus             = w_nread_alu_b ? 'z : r_b;
    assign bus.a            = r_a;
    assign bus.b            = r_b;
    assign bus.nread_alu_b  = w_nread_alu_b;
    assign bus.nwrite_alu_b = w_nwrite_alu_b;

endmodule

// File: tb/tb_alu_input_stage.sv
// Self-checking bench for alu_input_stage: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_alu_input_stage;
    import alu_pkg::*;

    logic        clk4;
    logic        nreset;
    logic        tb_en;
    logic [15:0] tb_bus;
    wire  [15:0] ibus;

    int unsigned total;
    int unsigned bad;
    logic [15:0] exp_a;
    logic [15:0] exp_b;

    alu_input_stage_if bus ();

    alu_input_stage dut (
        .clk4   (clk4),
        .nreset (nreset),
        .bus    (bus),
        .ibus   (ibus)
    );

    assign ibus = tb_en ? tb_bus : 'z;

    initial clk4 = 1'b0;
    always #5 clk4 = ~clk4;

    function automatic logic exp_nromoe(input logic [4:0] ra);
        return (ra >= 5'd24) ? 1'b0 : 1'b1;
    endfunction

    // {cll, cpl, sru, 101, 110}
    function automatic logic [4:0] exp_act(input logic [3:0] code, input logic t);
        logic [3:0] codes [5];
        logic [4:0] r;
        codes[0] = 4'd9; codes[1] = 4'd10; codes[2] = 4'd11;
        codes[3] = 4'd13; codes[4] = 4'd14;
        r = 5'b11111;
        if (t) begin
            for (int i = 0; i < 5; i++) begin
                if (code == codes[i]) r[4-i] = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic logic [4:0] obs_act();
        return {bus.naction_cll, bus.naction_cpl, bus.naction_sru,
                bus.naction_101, bus.naction_110};
    endfunction

    task automatic tick();
        @(posedge clk4);
        #1;
    endtask

    task automatic idle_inputs();
        bus.t34 = 1'b0; bus.raddr = 5'h00; bus.waddr = 5'h00;
        bus.action = 4'h0; bus.nbcp_sru = 1'b1; tb_en = 1'b0;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        idle_inputs();
        bus.ac = 16'h1234;
        tb_bus = 16'h0000;
        repeat (3) tick();
        total++; if (bus.a !== 16'h0000) begin bad++; $display("FAIL reset_a got=%h exp=0000", bus.a); end
        total++; if (bus.b !== 16'h0000) begin bad++; $display("FAIL reset_b got=%h exp=0000", bus.b); end
        total++; if (bus.nread_alu_b !== 1'b1) begin bad++; $display("FAIL reset_nread got=%b exp=1", bus.nread_alu_b); end
        bus.raddr = 5'h18;
        #1;
        total++; if (bus.nromoe !== 1'b0) begin bad++; $display("FAIL reset_decode got=%b exp=0", bus.nromoe); end
        bus.raddr = 5'h00;
        nreset = 1'b1;
        tick();
        total++; if (bus.a !== 16'h1234) begin bad++; $display("FAIL reset_first_a got=%h exp=1234", bus.a); end
        total++; if (bus.b !== 16'h0000) begin bad++; $display("FAIL reset_first_b got=%h exp=0000", bus.b); end
        exp_a = 16'h1234; exp_b = 16'h0000;
    endtask

    task automatic test_port_a();
        logic [15:0] vals [2];
        vals[0] = 16'hAAAA; vals[1] = 16'h5555;
        for (int i = 0; i < 2; i++) begin
            bus.ac = vals[i];
            tick();
            total++; if (bus.a !== vals[i]) begin bad++; $display("FAIL port_a[%0d] got=%h exp=%h", i, bus.a, vals[i]); end
            total++; if (bus.b !== exp_b) begin bad++; $display("FAIL port_a_b_hold[%0d] got=%h exp=%h", i, bus.b, exp_b); end
        end
        exp_a = 16'h5555;
    endtask

    task automatic test_write_b();
        bus.waddr = 5'h07; bus.t34 = 1'b1; tb_en = 1'b1; tb_bus = 16'hBEEF;
        #1;
        total++; if (bus.nwrite_alu_b !== 1'b0) begin bad++; $display("FAIL write_strobe got=%b exp=0", bus.nwrite_alu_b); end
        tick();
        total++; if (bus.b !== 16'hBEEF) begin bad++; $display("FAIL write_b got=%h exp=BEEF", bus.b); end
        bus.t34 = 1'b0; tb_bus = 16'h1234;
        #1;
        total++; if (bus.nwrite_alu_b !== 1'b1) begin bad++; $display("FAIL write_strobe_t34 got=%b exp=1", bus.nwrite_alu_b); end
        tick();
        total++; if (bus.b !== 16'hBEEF) begin bad++; $display("FAIL write_b_no_t34 got=%h exp=BEEF", bus.b); end
        idle_inputs();
        exp_b = 16'hBEEF;
    endtask

    task automatic test_sru_load();
        bus.nbcp_sru = 1'b0; tb_en = 1'b1; tb_bus = 16'h0F0F;
        tick();
        total++; if (bus.b !== 16'h0F0F) begin bad++; $display("FAIL sru_load got=%h exp=0F0F", bus.b); end
        bus.nbcp_sru = 1'b1; tb_bus = 16'h3333;
        tick();
        total++; if (bus.b !== 16'h0F0F) begin bad++; $display("FAIL sru_hold got=%h exp=0F0F", bus.b); end
        bus.nbcp_sru = 1'b0; bus.waddr = 5'h07; bus.t34 = 1'b1; tb_bus = 16'h5A5A;
        tick();
        total++; if (bus.b !== 16'h5A5A) begin bad++; $display("FAIL sru_and_write got=%h exp=5A5A", bus.b); end
        idle_inputs();
        exp_b = 16'h5A5A;
    endtask

    task automatic test_read_b();
        bus.waddr = 5'h07; bus.t34 = 1'b1; tb_en = 1'b1; tb_bus = 16'hBEEF;
        tick();
        idle_inputs();
        bus.raddr = 5'h07;
        #1;
        total++; if (bus.nread_alu_b !== 1'b0) begin bad++; $display("FAIL read_strobe got=%b exp=0", bus.nread_alu_b); end
        total++; if (ibus !== 16'hBEEF) begin bad++; $display("FAIL read_ibus got=%h exp=BEEF", ibus); end
        // Release check: a bench-driven zero must reach the bus undisturbed.
        bus.raddr = 5'h00; tb_en = 1'b1; tb_bus = 16'h0000;
        #1;
        total++; if (bus.nread_alu_b !== 1'b1) begin bad++; $display("FAIL read_release_strobe got=%b exp=1", bus.nread_alu_b); end
        total++; if (ibus !== 16'h0000) begin bad++; $display("FAIL read_release_ibus got=%h exp=0000", ibus); end
        tb_en = 1'b0;
        bus.raddr = 5'h07; bus.waddr = 5'h07; bus.t34 = 1'b1;
        tick();
        total++; if (bus.b !== 16'hBEEF) begin bad++; $display("FAIL read_write_same got=%h exp=BEEF", bus.b); end
        idle_inputs();
        exp_b = 16'hBEEF;
    endtask

    task automatic test_decode_sweep();
        logic [4:0] exp_v;
        for (int r = 0; r < 32; r++) begin
            bus.raddr = 5'(r);
            #1;
            total++; if (bus.nromoe !== exp_nromoe(5'(r))) begin bad++; $display("FAIL sweep_nromoe raddr=%h got=%b exp=%b", r, bus.nromoe, exp_nromoe(5'(r))); end
            total++; if (bus.nread_alu_b !== (r == 7 ? 1'b0 : 1'b1)) begin bad++; $display("FAIL sweep_nread raddr=%h got=%b", r, bus.nread_alu_b); end
        end
        bus.raddr = 5'h00;
        for (int t = 0; t < 2; t++) begin
            bus.t34 = t[0];
            for (int w = 0; w < 32; w++) begin
                bus.waddr = 5'(w);
                #1;
                total++; if (bus.nwrite_alu_b !== ((w == 7 && t == 1) ? 1'b0 : 1'b1)) begin bad++; $display("FAIL sweep_nwrite waddr=%h t34=%0d got=%b", w, t, bus.nwrite_alu_b); end
            end
            bus.waddr = 5'h00;
            for (int c = 0; c < 16; c++) begin
                bus.action = 4'(c);
                #1;
                exp_v = exp_act(4'(c), t[0]);
                total++; if (obs_act() !== exp_v) begin bad++; $display("FAIL sweep_action code=%h t34=%0d got=%b exp=%b", c, t, obs_act(), exp_v); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic        reading;
        logic        load;
        logic [15:0] bus_val;
        logic [15:0] next_b;
        for (int n = 0; n < 300; n++) begin
            bus.raddr    = ($urandom_range(0, 3) == 0) ? 5'h07 : 5'($urandom_range(0, 31));
            bus.waddr    = ($urandom_range(0, 3) == 0) ? 5'h07 : 5'($urandom_range(0, 31));
            bus.action   = 4'($urandom_range(0, 15));
            bus.t34      = 1'($urandom_range(0, 1));
            bus.nbcp_sru = ($urandom_range(0, 4) != 0);
            bus.ac       = 16'($urandom);
            reading      = (bus.raddr == 5'h07);
            tb_en        = !reading;
            tb_bus       = 16'($urandom);
            #1;
            total++; if (bus.nromoe !== exp_nromoe(bus.raddr)) begin bad++; $display("FAIL rand_nromoe n=%0d got=%b", n, bus.nromoe); end
            total++; if (bus.nread_alu_b !== !reading) begin bad++; $display("FAIL rand_nread n=%0d got=%b", n, bus.nread_alu_b); end
            total++; if (bus.nwrite_alu_b !== !(bus.waddr == 5'h07 && bus.t34)) begin bad++; $display("FAIL rand_nwrite n=%0d got=%b", n, bus.nwrite_alu_b); end
            total++; if (obs_act() !== exp_act(bus.action, bus.t34)) begin bad++; $display("FAIL rand_action n=%0d got=%b exp=%b", n, obs_act(), exp_act(bus.action, bus.t34)); end
            if (reading) begin
                total++; if (ibus !== exp_b) begin bad++; $display("FAIL rand_ibus n=%0d got=%h exp=%h", n, ibus, exp_b); end
            end
            bus_val = reading ? exp_b : tb_bus;
            load    = (bus.waddr == 5'h07 && bus.t34) || !bus.nbcp_sru;
            next_b  = load ? bus_val : exp_b;
            tick();
            exp_a = bus.ac;
            exp_b = next_b;
            total++; if (bus.a !== exp_a) begin bad++; $display("FAIL rand_a n=%0d got=%h exp=%h", n, bus.a, exp_a); end
            total++; if (bus.b !== exp_b) begin bad++; $display("FAIL rand_b n=%0d got=%h exp=%h", n, bus.b, exp_b); end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        bus.ac = 16'hC3C3; bus.nbcp_sru = 1'b0; tb_en = 1'b1; tb_bus = 16'h7E7E;
        tick();
        idle_inputs();
        total++; if (bus.b !== 16'h7E7E) begin bad++; $display("FAIL async_pre_b got=%h exp=7E7E", bus.b); end
        #2;
        nreset = 1'b0;
        #1;
        total++; if (bus.a !== 16'h0000) begin bad++; $display("FAIL async_a got=%h exp=0000", bus.a); end
        total++; if (bus.b !== 16'h0000) begin bad++; $display("FAIL async_b got=%h exp=0000", bus.b); end
        bus.nbcp_sru = 1'b0; tb_en = 1'b1;
        repeat (2) tick();
        total++; if (bus.b !== 16'h0000) begin bad++; $display("FAIL async_hold_b got=%h exp=0000", bus.b); end
        idle_inputs();
        nreset = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_port_a();
        test_write_b();
        test_sru_load();
        test_read_b();
        test_decode_sweep();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
